// File: rtl/tetris_playfield_engine.sv
// Tetris playfield engine: occupancy grid, move/collision checks, piece lock, row clear, score, pixel lookup.
// Build option MULTI_LINE_BONUS_EN: score adds 1/3/5/8 for 1..4 rows cleared by one lock instead of 1 per row.
module tetris_playfield_engine #(
  parameter int COLS    = 12,
  parameter int ROWS    = 24,
  parameter int CELL_PX = 20,
  parameter int SCORE_W = 16,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_N,
  input  logic               start_over,
  input  logic               move_req,
  input  logic [1:0]         move_dir,
  input  logic [1:0]         piece_shape,
  input  logic [CW-1:0]      piece_col,
  input  logic [RW-1:0]      piece_row,
  output logic               busy,
  output logic               done,
  output logic               move_ok,
  output logic               locked,
  output logic [2:0]         rows_cleared,
  output logic [SCORE_W-1:0] score,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic               pix_on
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_LOCK  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;

  localparam logic [1:0] D_DOWN  = 2'd0;
  localparam logic [1:0] D_LEFT  = 2'd1;
  localparam logic [1:0] D_RIGHT = 2'd2;

  typedef logic signed [7:0] crd_t;
  localparam crd_t COLS_C = crd_t'(COLS);
  localparam crd_t ROWS_C = crd_t'(ROWS);

  logic [2:0]                  state;
  logic [1:0]                  l_shape, l_dir;
  logic [CW-1:0]               l_col;
  logic [RW-1:0]               l_row;
  logic [ROWS-1:0][COLS-1:0]   grid;
  logic [RW-1:0]               ptr, sptr;
  logic [2:0]                  k;

  // Cell offsets inside the 4x4 box, packed as {row[1:0], col[1:0]}.
  function automatic logic [3:0] cell_off(input logic [1:0] shape, input logic [1:0] idx);
    case (shape)
      2'd0:    cell_off = {1'b0, idx[1], 1'b0, idx[0]};
      2'd1:    cell_off = {2'd0, idx};
      2'd2:    cell_off = {idx, 2'd0};
      default: cell_off = (idx == 2'd3) ? 4'b0101 : {2'd0, idx};
    endcase
  endfunction

  crd_t                   base_r, base_c, off_r, off_c;
  logic                   blocked;
  logic [3:0]             cur_in;
  logic [3:0][RW-1:0]     cur_r;
  logic [3:0][CW-1:0]     cur_c;

  always_comb begin
    base_r  = {{(8-RW){1'b0}}, l_row};
    base_c  = {{(8-CW){1'b0}}, l_col};
    off_r   = (l_dir == D_DOWN) ? 8'sd1 : 8'sd0;
    off_c   = (l_dir == D_LEFT) ? -8'sd1 : (l_dir == D_RIGHT) ? 8'sd1 : 8'sd0;
    blocked = 1'b0;
    cur_in  = '0;
    cur_r   = '0;
    cur_c   = '0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] o;
      crd_t tr, tc, cr, cc;
      o  = cell_off(l_shape, 2'(i));
      cr = base_r + crd_t'({6'd0, o[3:2]});
      cc = base_c + crd_t'({6'd0, o[1:0]});
      tr = cr + off_r;
      tc = cc + off_c;
      if (tc < 0 || tc >= COLS_C || tr >= ROWS_C) blocked = 1'b1;
      else if (grid[tr[RW-1:0]][tc[CW-1:0]])       blocked = 1'b1;
      // Lock uses the unoffset position; cells off the grid are simply dropped.
      cur_in[i] = (cr < ROWS_C) && (cc < COLS_C);
      cur_r[i]  = cr[RW-1:0];
      cur_c[i]  = cc[CW-1:0];
    end
  end

  logic [3:0]         add;
  logic [SCORE_W:0]   sum;

  always_comb begin
`ifdef MULTI_LINE_BONUS_EN
    case (k)
      3'd1:    add = 4'd1;
      3'd2:    add = 4'd3;
      3'd3:    add = 4'd5;
      3'd4:    add = 4'd8;
      default: add = 4'd0;
    endcase
`else
    add = {1'b0, k};
`endif
    sum = {1'b0, score} + (SCORE_W+1)'(add);
  end

  logic [9:0] px_col, px_row;
  logic       pix_hit;

  assign px_col = pix_x / 10'(CELL_PX);
  assign px_row = pix_y / 10'(CELL_PX);

  always_comb begin
    pix_hit = 1'b0;
    if (px_row < 10'(ROWS)) begin
      if (px_col < 10'(COLS))       pix_hit = grid[px_row[RW-1:0]][px_col[CW-1:0]];
      else if (px_col == 10'(COLS)) pix_hit = 1'b1;
    end
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= S_IDLE;
      l_shape      <= '0;
      l_dir        <= '0;
      l_col        <= '0;
      l_row        <= '0;
      grid         <= '0;
      ptr          <= '0;
      sptr         <= '0;
      k            <= '0;
      done         <= 1'b0;
      move_ok      <= 1'b0;
      locked       <= 1'b0;
      rows_cleared <= '0;
      score        <= '0;
      pix_on       <= 1'b0;
    end else begin
      done         <= 1'b0;
      move_ok      <= 1'b0;
      locked       <= 1'b0;
      rows_cleared <= '0;
      pix_on       <= pix_hit;
      if (start_over) begin
        grid  <= '0;
        score <= '0;
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (move_req) begin
            l_shape <= piece_shape;
            l_dir   <= move_dir;
            l_col   <= piece_col;
            l_row   <= piece_row;
            state   <= S_CHECK;
          end
          S_CHECK: begin
            if (!blocked) begin
              done    <= 1'b1;
              move_ok <= 1'b1;
              state   <= S_IDLE;
            end else if (l_dir != D_DOWN) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              state <= S_LOCK;
            end
          end
          S_LOCK: begin
            for (int i = 0; i < 4; i++)
              if (cur_in[i]) grid[cur_r[i]][cur_c[i]] <= 1'b1;
            k     <= '0;
            ptr   <= RW'(ROWS-1);
            state <= S_SCAN;
          end
          S_SCAN: begin
            if (&grid[ptr]) begin
              sptr  <= ptr;
              state <= S_SHIFT;
            end else if (ptr == '0) begin
              done         <= 1'b1;
              locked       <= 1'b1;
              rows_cleared <= k;
              score        <= sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
              state        <= S_IDLE;
            end else begin
              ptr <= ptr - 1'b1;
            end
          end
          S_SHIFT: begin
            // Scan resumes at the same row so the row that dropped in is rechecked.
            if (sptr == '0) begin
              grid[0] <= '0;
              k       <= k + 3'd1;
              state   <= S_SCAN;
            end else begin
              grid[sptr] <= grid[sptr - 1'b1];
              sptr       <= sptr - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
